regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//   Shares the single write port of the 16x16 register file between NUM_REQ write-back
//   sources (ALU, load unit, mul/div) via round-robin arbitration with valid/ready handshakes.
//   Keeps a per-register busy scoreboard (reserve at issue, clear at write-back) for decode stall checks.
//   Sits between execute/memory stages and the register file write port.
// PARAMETERS
//   NUM_REQ   3   number of write-back requesters (2..8)
//   DATA_W   16   register data width
//   ADDR_W    4   register address width
//   NUM_REGS 16   number of registers (2**ADDR_W)
// PORTS
//   clk            in   1                 clock, rising edge
//   rst            in   1                 reset, asynchronous, active-high
//   req_valid      in   NUM_REQ           requester i has a result to write
//   req_dest       in   NUM_REQ*ADDR_W    dest of requester i, slice [i*ADDR_W +: ADDR_W]
//   req_data       in   NUM_REQ*DATA_W    data of requester i, slice [i*DATA_W +: DATA_W]
//   req_ready      out  NUM_REQ           one-hot grant; transfer when valid&ready
//   rf_write_en    out  1                 to register file write enable (registered)
//   rf_write_dest  out  ADDR_W            to register file write address (registered)
//   rf_write_data  out  DATA_W            to register file write data (registered)
//   reserve_en     in   1                 decode issues an instruction writing reserve_dest
//   reserve_dest   in   ADDR_W            register to mark busy
//   query_addr_1/2 in   ADDR_W            decode source operand addresses
//   query_busy_1/2 out  1                 source has a pending producer (combinational)
//   fwd_hit_1/2    out  1                 forward data valid (WB_FORWARD_EN)
//   fwd_data_1/2   out  DATA_W            forward data (WB_FORWARD_EN)
//   busy_mask      out  NUM_REGS          scoreboard contents, bit r = register r busy
// BEHAVIOUR
//   - Reset (async): rr pointer=0, busy_mask=0, rf_write_en=0, rf_write_dest=0, rf_write_data=0.
//   - Arbitration: combinational; search starts at pointer, wraps mod NUM_REQ; first valid wins.
//     req_ready = one-hot of winner, all 0 if no valid. Max one grant per cycle.
//   - Pointer: on a grant to i, pointer <= (i+1) mod NUM_REQ; unchanged if no grant.
//   - Write stage: one cycle latency. Edge after grant: rf_write_en=1 and dest/data=winner's;
//     no grant -> rf_write_en=0, dest/data hold previous values.
//   - Dest r0: grant and handshake proceed, rf_write_en stays 0 (r0 is hardwired zero).
//   - Requesters hold valid/dest/data stable until ready; scheduler never drops an accepted write.
//   - Scoreboard: reserve_en sets busy[reserve_dest] at next edge; a grant clears busy[dest].
//     Same edge, same register reserve and clear -> busy stays 1 (newer producer wins).
//     reserve_dest=0 ignored; busy[0] is always 0.
//   - query_busy_n = busy_mask[query_addr_n]; address 0 -> 0.
//   - Reset mid-operation: in-flight rf_write_en cleared immediately; pending grants lost.
// CONFIGURATION
//   WB_FORWARD_EN defined: fwd_hit_n = rf_write_en & (rf_write_dest==query_addr_n) & (query_addr_n!=0);
//     fwd_data_n = rf_write_data. Covers the cycle in which the file has not yet captured the write.
//   WB_FORWARD_EN undefined: fwd_hit_n = 0, fwd_data_n = 0; ports still present.
// STRUCTURE
//   Package regfile_pkg: DATA_W, ADDR_W, NUM_REGS, REG_ZERO (=0) constants; typedefs reg_addr_t, reg_data_t.
//   Sub-module rr_arbiter (NUM_REQ, pointer-based round-robin, one-hot grant out, pointer state inside).
//   Top holds write-stage registers, scoreboard, query/forward logic.
// TESTING
//   - Reset: assert rst mid-write -> rf_write_en=0, busy_mask=0 the same cycle, pointer restarts at 0.
//   - All 3 valid continuously, dests 1,2,3 -> grants 0,1,2,0...; rf_write_en=1 each cycle, one cycle after grant.
//   - Only req1 valid, dest=5, data=16'hBEEF -> ready[1]=1 same cycle; next cycle rf_write_dest=5, data=BEEF.
//   - reserve_en dest=7, later grant dest=7 -> query_busy for 7 is 1 until edge of grant, then 0.
//   - Same edge reserve 4 and grant dest 4 -> busy_mask[4] remains 1.
//   - req0 dest=0 data=16'h1234 -> ready[0]=1, rf_write_en stays 0; reserve_dest=0 leaves busy_mask=0.
//   - WB_FORWARD_EN: write dest=3 data=16'h00AA, query_addr_1=3 in write cycle -> fwd_hit_1=1, fwd_data_1=00AA;
//     without macro -> fwd_hit_1=0.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Register-file constants and types shared by the write-back scheduler slice.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = {ADDR_W{1'b0}};

  // One-hot register select used by the busy scoreboard.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] mask;
    mask       = {NUM_REGS{1'b0}};
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back request bus: NUM_REQ producers offering results with a valid/ready handshake.
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_dest,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dest,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter: search starts at the pointer, wraps, first valid wins.
module rr_arbiter #(
  parameter int  NUM_REQ = 3,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [PTR_W-1:0]   o_grant_idx
);

  localparam int IDX_W = PTR_W + 1;

  logic [PTR_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;

  // Priority search from the pointer; the sum is reduced once since both terms are < NUM_REQ.
  always_comb begin
    o_grant     = {NUM_REQ{1'b0}};
    o_grant_vld = 1'b0;
    o_grant_idx = {PTR_W{1'b0}};
    w_idx       = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IDX_W'(k);
      if (w_idx >= IDX_W'(NUM_REQ)) begin
        w_idx = w_idx - IDX_W'(NUM_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (!o_grant_vld && i_valid[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        o_grant_vld               = 1'b1;
        o_grant_idx               = w_idx[PTR_W-1:0];
      end else begin
        o_grant_vld = o_grant_vld;
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= {PTR_W{1'b0}};
    end else if (o_grant_vld) begin
      r_ptr <= (o_grant_idx == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : o_grant_idx + PTR_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the single register-file write port and tracks busy registers.
// Optional bypass of the in-flight write to decode is enabled by defining WB_FORWARD_EN.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_scheduler_if.slave   io_wb,
  output logic                    o_rf_write_en,
  output reg_addr_t               o_rf_write_dest,
  output reg_data_t               o_rf_write_data,
  input  logic                    i_reserve_en,
  input  reg_addr_t               i_reserve_dest,
  input  reg_addr_t               i_query_addr_1,
  input  reg_addr_t               i_query_addr_2,
  output logic                    o_query_busy_1,
  output logic                    o_query_busy_2,
  output logic                    o_fwd_hit_1,
  output logic                    o_fwd_hit_2,
  output reg_data_t               o_fwd_data_1,
  output reg_data_t               o_fwd_data_2,
  output logic [NUM_REGS-1:0]     o_busy_mask
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_vld;
  logic [PTR_W-1:0]    w_grant_idx;
  reg_addr_t           w_win_dest;
  reg_data_t           w_win_data;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_wen;
  reg_addr_t           r_dest;
  reg_data_t           r_data;
  logic [NUM_REGS-1:0] r_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (io_wb.req_valid),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld),
    .o_grant_idx (w_grant_idx)
  );

  assign io_wb.req_ready = w_grant;

  // Select the winning requester's destination and data.
  always_comb begin
    w_win_dest = io_wb.req_dest[w_grant_idx*ADDR_W +: ADDR_W];
    w_win_data = io_wb.req_data[w_grant_idx*DATA_W +: DATA_W];
  end

  // Write stage: one cycle after the grant; r0 writes are accepted but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_dest <= REG_ZERO;
      r_data <= {DATA_W{1'b0}};
    end else if (w_grant_vld) begin
      r_wen  <= (w_win_dest != REG_ZERO);
      r_dest <= w_win_dest;
      r_data <= w_win_data;
    end else begin
      r_wen  <= 1'b0;
      r_dest <= r_dest;
      r_data <= r_data;
    end
  end

  // Scoreboard update: set applied after clear so a fresh reservation survives a same-edge write-back.
  always_comb begin
    w_set = {NUM_REGS{1'b0}};
    w_clr = {NUM_REGS{1'b0}};
    if (i_reserve_en && (i_reserve_dest != REG_ZERO)) begin
      w_set = reg_onehot(i_reserve_dest);
    end else begin
      w_set = {NUM_REGS{1'b0}};
    end
    if (w_grant_vld) begin
      w_clr = reg_onehot(w_win_dest);
    end else begin
      w_clr = {NUM_REGS{1'b0}};
    end
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~reg_onehot(REG_ZERO);
  end

  // Busy scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= {NUM_REGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_rf_write_en   = r_wen;
  assign o_rf_write_dest = r_dest;
  assign o_rf_write_data = r_data;
  assign o_busy_mask     = r_busy;
  assign o_query_busy_1  = r_busy[i_query_addr_1] & (i_query_addr_1 != REG_ZERO);
  assign o_query_busy_2  = r_busy[i_query_addr_2] & (i_query_addr_2 != REG_ZERO);

`ifdef WB_FORWARD_EN
  // Bypass covers the cycle in which the register file has not yet captured the write.
  assign o_fwd_hit_1  = r_wen & (r_dest == i_query_addr_1) & (i_query_addr_1 != REG_ZERO);
  assign o_fwd_hit_2  = r_wen & (r_dest == i_query_addr_2) & (i_query_addr_2 != REG_ZERO);
  assign o_fwd_data_1 = r_data;
  assign o_fwd_data_2 = r_data;
`else
  assign o_fwd_hit_1  = 1'b0;
  assign o_fwd_hit_2  = 1'b0;
  assign o_fwd_data_1 = {DATA_W{1'b0}};
  assign o_fwd_data_2 = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler (expectations follow WB_FORWARD_EN).
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic                clk;
  logic                rst;
  logic                reserve_en;
  reg_addr_t           reserve_dest;
  reg_addr_t           query_addr_1;
  reg_addr_t           query_addr_2;
  logic                rf_write_en;
  reg_addr_t           rf_write_dest;
  reg_data_t           rf_write_data;
  logic                query_busy_1;
  logic                query_busy_2;
  logic                fwd_hit_1;
  logic                fwd_hit_2;
  reg_data_t           fwd_data_1;
  reg_data_t           fwd_data_2;
  logic [NUM_REGS-1:0] busy_mask;

  int n_vec;
  int n_err;

  regfile_wb_scheduler_if #(.NUM_REQ(3)) wb ();

  regfile_wb_scheduler #(.NUM_REQ(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .io_wb           (wb.slave),
    .o_rf_write_en   (rf_write_en),
    .o_rf_write_dest (rf_write_dest),
    .o_rf_write_data (rf_write_data),
    .i_reserve_en    (reserve_en),
    .i_reserve_dest  (reserve_dest),
    .i_query_addr_1  (query_addr_1),
    .i_query_addr_2  (query_addr_2),
    .o_query_busy_1  (query_busy_1),
    .o_query_busy_2  (query_busy_2),
    .o_fwd_hit_1     (fwd_hit_1),
    .o_fwd_hit_2     (fwd_hit_2),
    .o_fwd_data_1    (fwd_data_1),
    .o_fwd_data_2    (fwd_data_2),
    .o_busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] d, input logic [15:0] x);
    wb.req_valid[i]          = v;
    wb.req_dest[i*4 +: 4]    = d;
    wb.req_data[i*16 +: 16]  = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_rdy;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    wb.req_valid = 3'b000;
    wb.req_dest  = 12'h000;
    wb.req_data  = 48'h0;
    reserve_en   = 1'b0;
    reserve_dest = 4'd0;
    query_addr_1 = 4'd0;
    query_addr_2 = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen",  {31'd0, rf_write_en}, 32'd0);
    chk("reset_dest", {28'd0, rf_write_dest}, 32'd0);
    chk("reset_data", {16'd0, rf_write_data}, 32'd0);
    chk("reset_busy", {16'd0, busy_mask}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All three valid: grants rotate 0,1,2,0 from a reset pointer.
    set_req(0, 1'b1, 4'd1, 16'h0011);
    set_req(1, 1'b1, 4'd2, 16'h0022);
    set_req(2, 1'b1, 4'd3, 16'h0033);
    for (int c = 0; c < 4; c++) begin
      exp_rdy = 3'b001 << (c % 3);
      #1;
      chk("rr_ready", {29'd0, wb.req_ready}, {29'd0, exp_rdy});
      tick();
      chk("rr_wen",  {31'd0, rf_write_en}, 32'd1);
      chk("rr_dest", {28'd0, rf_write_dest}, 32'((c % 3) + 1));
      chk("rr_data", {16'd0, rf_write_data}, 32'(16'h0011 * ((c % 3) + 1)));
    end
    wb.req_valid = 3'b000;
    #1;
    chk("idle_ready", {29'd0, wb.req_ready}, 32'd0);
    tick();
    chk("idle_wen",  {31'd0, rf_write_en}, 32'd0);
    chk("idle_dest", {28'd0, rf_write_dest}, 32'd1);
    chk("idle_data", {16'd0, rf_write_data}, 32'h0011);

    // Single requester 1 (pointer at 1 afterwards moves to 2).
    set_req(1, 1'b1, 4'd5, 16'hBEEF);
    #1;
    chk("r1_ready", {29'd0, wb.req_ready}, 32'b010);
    tick();
    wb.req_valid = 3'b000;
    chk("r1_wen",  {31'd0, rf_write_en}, 32'd1);
    chk("r1_dest", {28'd0, rf_write_dest}, 32'd5);
    chk("r1_data", {16'd0, rf_write_data}, 32'hBEEF);

    // Reserve 7, then write it back from requester 2.
    reserve_en = 1'b1; reserve_dest = 4'd7; query_addr_1 = 4'd7;
    #1;
    chk("rsv7_pre", {31'd0, query_busy_1}, 32'd0);
    tick();
    reserve_en = 1'b0;
    chk("rsv7_busy", {31'd0, query_busy_1}, 32'd1);
    chk("rsv7_mask", {16'd0, busy_mask}, 32'h0080);
    tick();
    chk("rsv7_hold", {31'd0, query_busy_1}, 32'd1);
    set_req(2, 1'b1, 4'd7, 16'h0077);
    #1;
    chk("wb7_ready", {29'd0, wb.req_ready}, 32'b100);
    chk("wb7_busy_before", {31'd0, query_busy_1}, 32'd1);
    tick();
    wb.req_valid = 3'b000;
    chk("wb7_busy_after", {31'd0, query_busy_1}, 32'd0);
    chk("wb7_mask", {16'd0, busy_mask}, 32'h0000);

    // Reserve 4 and write back 4 on the same edge: reservation wins.
    reserve_en = 1'b1; reserve_dest = 4'd4; query_addr_2 = 4'd4;
    tick();
    set_req(0, 1'b1, 4'd4, 16'h0044);
    #1;
    chk("same_ready", {29'd0, wb.req_ready}, 32'b001);
    tick();
    reserve_en = 1'b0;
    wb.req_valid = 3'b000;
    chk("same_mask", {16'd0, busy_mask}, 32'h0010);
    chk("same_q2",   {31'd0, query_busy_2}, 32'd1);
    chk("same_wen",  {31'd0, rf_write_en}, 32'd1);
    set_req(1, 1'b1, 4'd4, 16'h0444);
    #1;
    chk("clr4_ready", {29'd0, wb.req_ready}, 32'b010);
    tick();
    wb.req_valid = 3'b000;
    chk("clr4_mask", {16'd0, busy_mask}, 32'h0000);

    // Destination r0: handshake completes, no write, no reservation.
    set_req(0, 1'b1, 4'd0, 16'h1234);
    reserve_en = 1'b1; reserve_dest = 4'd0; query_addr_1 = 4'd0;
    #1;
    chk("r0_ready", {29'd0, wb.req_ready}, 32'b001);
    tick();
    wb.req_valid = 3'b000;
    reserve_en = 1'b0;
    chk("r0_wen",  {31'd0, rf_write_en}, 32'd0);
    chk("r0_mask", {16'd0, busy_mask}, 32'h0000);
    chk("r0_q1",   {31'd0, query_busy_1}, 32'd0);

    // Forwarding of the in-flight write.
    set_req(1, 1'b1, 4'd3, 16'h00AA);
    #1;
    chk("fwd_ready", {29'd0, wb.req_ready}, 32'b010);
    tick();
    wb.req_valid = 3'b000;
    query_addr_1 = 4'd3; query_addr_2 = 4'd5;
    #1;
    chk("fwd_wen", {31'd0, rf_write_en}, 32'd1);
`ifdef WB_FORWARD_EN
    chk("fwd_hit1",  {31'd0, fwd_hit_1}, 32'd1);
    chk("fwd_data1", {16'd0, fwd_data_1}, 32'h00AA);
`else
    chk("fwd_hit1",  {31'd0, fwd_hit_1}, 32'd0);
    chk("fwd_data1", {16'd0, fwd_data_1}, 32'h0000);
`endif
    chk("fwd_hit2",  {31'd0, fwd_hit_2}, 32'd0);

    // Reset in the middle of a write with a live reservation.
    set_req(0, 1'b1, 4'd9, 16'h0099);
    reserve_en = 1'b1; reserve_dest = 4'd9;
    #1;
    chk("mid_ready", {29'd0, wb.req_ready}, 32'b001);
    tick();
    wb.req_valid = 3'b000;
    reserve_en = 1'b0;
    chk("mid_wen",  {31'd0, rf_write_en}, 32'd1);
    chk("mid_mask", {16'd0, busy_mask}, 32'h0200);
    rst = 1'b1;
    #1;
    chk("rst_wen",  {31'd0, rf_write_en}, 32'd0);
    chk("rst_mask", {16'd0, busy_mask}, 32'h0000);
    chk("rst_dest", {28'd0, rf_write_dest}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 4'd1, 16'h0101);
    set_req(1, 1'b1, 4'd2, 16'h0202);
    #1;
    chk("rst_ptr_ready", {29'd0, wb.req_ready}, 32'b001);
    tick();
    wb.req_valid = 3'b000;
    chk("rst_ptr_dest", {28'd0, rf_write_dest}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
